// File: rtl/video_timing.sv
// Raster timing generator: pixel enable, sync/blank strobes and pixel coordinates
// for a 320x240 raster with NTSC or PAL vertical timing switched on frame boundaries.
module video_timing #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = 320,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 32,
  parameter int unsigned H_BP      = 32,
  parameter int unsigned V_ACTIVE  = 240,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_FP_NTSC = 3,
  parameter int unsigned V_BP_NTSC = 16,
  parameter int unsigned V_FP_PAL  = 28,
  parameter int unsigned V_BP_PAL  = 41
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       pal,
  output logic       ce_pixel,
  output logic       hs,
  output logic       vs,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic [9:0] hcount,
  output logic [8:0] vcount,
  output logic       frame_start,
  output logic       pal_active
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL_N = V_ACTIVE + V_FP_NTSC + V_SYNC + V_BP_NTSC;
  localparam int unsigned V_TOTAL_P = V_ACTIVE + V_FP_PAL + V_SYNC + V_BP_PAL;
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [8:0] V_ACT      = 9'(V_ACTIVE);
  localparam logic [8:0] V_LAST_N   = 9'(V_TOTAL_N - 1);
  localparam logic [8:0] V_LAST_P   = 9'(V_TOTAL_P - 1);
  localparam logic [8:0] VS_START_N = 9'(V_ACTIVE + V_FP_NTSC);
  localparam logic [8:0] VS_END_N   = 9'(V_ACTIVE + V_FP_NTSC + V_SYNC - 1);
  localparam logic [8:0] VS_START_P = 9'(V_ACTIVE + V_FP_PAL);
  localparam logic [8:0] VS_END_P   = 9'(V_ACTIVE + V_FP_PAL + V_SYNC - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_timing: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > 1024) begin : g_bad_h
    $error("video_timing: horizontal total does not fit a 10-bit counter");
  end
  if ((V_TOTAL_N > 512) || (V_TOTAL_P > 512)) begin : g_bad_v
    $error("video_timing: vertical total does not fit a 9-bit counter");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_pixel_q, ce_pixel_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [8:0]       vcount_q, vcount_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             hblank_q, hblank_d;
  logic             vblank_q, vblank_d;
  logic             de_q, de_d;
  logic             frame_start_q, frame_start_d;
  logic             pal_active_q, pal_active_d;

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [8:0] v_last;
  logic [8:0] vs_start;
  logic [8:0] vs_end;

  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    ce_pixel_d    = tick;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    de_d          = de_q;
    frame_start_d = 1'b0;
    pal_active_d  = pal_active_q;
    // Frame geometry always follows the mode latched at the last frame start.
    v_last        = pal_active_q ? V_LAST_P   : V_LAST_N;
    vs_start      = pal_active_q ? VS_START_P : VS_START_N;
    vs_end        = pal_active_q ? VS_END_P   : VS_END_N;
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == v_last);

    if (tick) begin
      hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 9'd0 : vcount_q + 9'd1;
      end
      frame_start_d = h_wrap && v_wrap;
      if (frame_start_d) begin
        pal_active_d = pal;
      end
      // Strobes decode the new position so they align with the counters.
      hblank_d = (hcount_d >= H_ACT);
      hs_d     = !((hcount_d >= HS_START) && (hcount_d <= HS_END));
      vblank_d = (vcount_d >= V_ACT);
      vs_d     = !((vcount_d >= vs_start) && (vcount_d <= vs_end));
      de_d     = !(hblank_d || vblank_d);
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      div_q         <= '0;
      ce_pixel_q    <= 1'b0;
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST_N;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      pal_active_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pixel_q    <= ce_pixel_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      pal_active_q  <= pal_active_d;
    end
  end

  assign ce_pixel    = ce_pixel_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign pal_active  = pal_active_q;

endmodule
